// File: rtl/calc_entry_ctrl_if.sv
// Keypad, ALU handshake and display bus of the calculator entry sequencer.
// slave = sequencer side, master = keypad/ALU/display environment side.
interface calc_entry_ctrl_if #(
   parameter int unsigned W = 16
);
   logic          key_valid;
   logic [4:0]    key_code;
   logic [W-1:0]  op1;
   logic [W-1:0]  op2;
   logic [2:0]    op;
   logic          alu_req;
   logic          alu_ack;
   logic [W-1:0]  alu_result;
   logic          alu_ovf;
   logic [W-1:0]  display;
   logic          ovf;
   logic          err;
   logic          digit_rej;

   modport master (
      output key_valid, key_code, alu_ack, alu_result, alu_ovf,
      input  op1, op2, op, alu_req, display, ovf, err, digit_rej
   );

   modport slave (
      input  key_valid, key_code, alu_ack, alu_result, alu_ovf,
      output op1, op2, op, alu_req, display, ovf, err, digit_rej
   );
endinterface

// File: rtl/calc_entry_ctrl.sv
// Keypad-to-ALU sequencer: hex operand entry, operator select, ALU req/ack with timeout.
// Define CALC_CHAIN_EN to let an operator key in SHOW chain on the previous result.
module calc_entry_ctrl #(
   parameter int unsigned W       = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input logic               clk,
   input logic               rst,
   calc_entry_ctrl_if.slave  bus
);
   localparam int unsigned CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [3:0] {
      S_OP1, S_CLR2, S_OP2, S_CLR_OP, S_SEL_OP, S_WAIT_ALU, S_SHOW, S_ERR, S_CLR_ALL
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  op1_q, op1_d, op2_q, op2_d, res_q, res_d;
   logic [2:0]    op_q, op_d;
   logic          ovf_q, ovf_d, rej_q, rej_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic k_digit, k_op, k_exe, k_back, k_clear, k_del;

   always_comb begin
      k_digit = bus.key_valid & ~bus.key_code[4];
      k_op    = bus.key_valid & (bus.key_code == 5'h10 || bus.key_code == 5'h11 ||
                                 bus.key_code == 5'h12 || bus.key_code == 5'h14 ||
                                 bus.key_code == 5'h15);
      k_exe   = bus.key_valid & (bus.key_code == 5'h13);
      k_back  = bus.key_valid & (bus.key_code == 5'h16);
      k_clear = bus.key_valid & (bus.key_code == 5'h17);
      k_del   = bus.key_valid & (bus.key_code == 5'h18);
   end

   // Shift a digit in (refused when the top nibble is occupied) or drop the last one.
   function automatic logic [W-1:0] edit(input logic [W-1:0] v, input logic dig,
                                         input logic del, input logic [3:0] d);
      logic [W-1:0] r;
      r = v;
      if (dig && v[W-1:W-4] == 4'h0) r = {v[W-5:0], d};
      else if (del)                  r = v >> 4;
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      op_d    = op_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      rej_d   = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_OP1: begin
            op1_d = edit(op1_q, k_digit, k_del, bus.key_code[3:0]);
            rej_d = k_digit & (op1_q[W-1:W-4] != 4'h0);
            if (k_exe)                 state_d = S_CLR2;
            else if (k_back | k_clear) state_d = S_CLR_ALL;
         end
         S_CLR2: begin
            op2_d   = '0;
            state_d = S_OP2;
         end
         S_OP2: begin
            op2_d = edit(op2_q, k_digit, k_del, bus.key_code[3:0]);
            rej_d = k_digit & (op2_q[W-1:W-4] != 4'h0);
            if (k_exe)        state_d = S_CLR_OP;
            else if (k_back)  state_d = S_CLR2;
            else if (k_clear) state_d = S_CLR_ALL;
         end
         S_CLR_OP: begin
            op_d    = 3'b111;
            state_d = S_SEL_OP;
         end
         S_SEL_OP: begin
            if (k_op) op_d = bus.key_code[2:0];
            if (k_exe && op_q != 3'b111) begin
               state_d = S_WAIT_ALU;
               cnt_d   = '0;
            end else if (k_back) begin
               state_d = S_CLR_OP;
            end else if (k_clear) begin
               state_d = S_CLR_ALL;
            end
         end
         S_WAIT_ALU: begin
            // Priority: CLEAR abort, then ack, then timeout.
            cnt_d = cnt_q + 1'b1;
            if (k_clear) begin
               state_d = S_CLR_ALL;
            end else if (bus.alu_ack) begin
               res_d   = bus.alu_result;
               ovf_d   = bus.alu_ovf;
               state_d = S_SHOW;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_ERR;
            end
         end
         S_SHOW: begin
            if (k_exe | k_clear) state_d = S_CLR_ALL;
`ifdef CALC_CHAIN_EN
            else if (k_op) begin
               op1_d   = res_q;
               op2_d   = '0;
               op_d    = bus.key_code[2:0];
               ovf_d   = 1'b0;
               state_d = S_OP2;
            end
`endif
         end
         S_ERR: begin
            if (k_exe | k_clear) state_d = S_CLR_ALL;
         end
         S_CLR_ALL: begin
            op1_d   = '0;
            op2_d   = '0;
            op_d    = 3'b111;
            ovf_d   = 1'b0;
            state_d = S_OP1;
         end
         default: state_d = S_OP1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_OP1;
         op1_q   <= '0;
         op2_q   <= '0;
         op_q    <= 3'b111;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         rej_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         op_q    <= op_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         rej_q   <= rej_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      unique case (state_q)
         S_OP1, S_CLR_ALL:                           bus.display = op1_q;
         S_CLR2, S_OP2, S_CLR_OP, S_SEL_OP, S_WAIT_ALU: bus.display = op2_q;
         S_SHOW:                                     bus.display = res_q;
         default:                                    bus.display = '0;
      endcase
   end

   assign bus.op1       = op1_q;
   assign bus.op2       = op2_q;
   assign bus.op        = op_q;
   assign bus.alu_req   = (state_q == S_WAIT_ALU);
   assign bus.err       = (state_q == S_ERR);
   assign bus.ovf       = (state_q == S_SHOW) & ovf_q;
   assign bus.digit_rej = rej_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl: directed test-plan sequences, then random keys,
// with expected outputs from a phase-level reference model queued per clock.
module tb_calc_entry_ctrl;
   localparam int unsigned W  = 16;
   localparam int unsigned TO = 8;

   typedef enum int {P_ENTRY1, P_CLR2, P_ENTRY2, P_CLROP, P_SELOP, P_WAIT, P_SHOW, P_ERR, P_CLRALL} phase_t;

   typedef struct {
      logic [W-1:0] op1, op2, disp;
      logic [2:0]   op;
      logic         req, ovf, err, rej, dv;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   calc_entry_ctrl_if #(.W(W)) bus ();

   calc_entry_ctrl #(.W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   exp_t   exp_q[$];
   int     checks = 0;
   int     errors = 0;

   // reference model
   phase_t      m_ph = P_ENTRY1;
   int unsigned m_a = 0, m_b = 0, m_res = 0, m_op = 7, m_wcnt = 0;
   bit          m_ov = 0, m_rej = 0;
   // ALU environment
   int          ack_at = 0;
   int          forced_delay = -1;
   bit          fix_res = 0;
   int unsigned fixed_res = 0;

   function automatic void chk(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
      end
   endfunction

   function automatic int unsigned enter(input int unsigned v, input int unsigned d, output bit rej);
      rej = 0;
      if (v < (1 << (W - 4))) return v * 16 + d;
      rej = 1;
      return v;
   endfunction

   task automatic model_step(input bit kv, input int unsigned kc, input bit ack,
                             input int unsigned ares, input bit aovf, input bit r);
      bit dig, opk, exe, back, clr, del;
      dig  = kv && kc < 16;
      opk  = kv && (kc == 16 || kc == 17 || kc == 18 || kc == 20 || kc == 21);
      exe  = kv && kc == 19;
      back = kv && kc == 22;
      clr  = kv && kc == 23;
      del  = kv && kc == 24;
      m_rej = 0;
      if (r) begin
         m_ph = P_ENTRY1; m_a = 0; m_b = 0; m_op = 7; m_res = 0; m_ov = 0; m_wcnt = 0;
         return;
      end
      case (m_ph)
         P_ENTRY1: begin
            if (dig) m_a = enter(m_a, kc, m_rej);
            if (del) m_a = m_a / 16;
            if (exe) m_ph = P_CLR2;
            if (back || clr) m_ph = P_CLRALL;
         end
         P_CLR2: begin m_b = 0; m_ph = P_ENTRY2; end
         P_ENTRY2: begin
            if (dig) m_b = enter(m_b, kc, m_rej);
            if (del) m_b = m_b / 16;
            if (exe) m_ph = P_CLROP;
            if (back) m_ph = P_CLR2;
            if (clr) m_ph = P_CLRALL;
         end
         P_CLROP: begin m_op = 7; m_ph = P_SELOP; end
         P_SELOP: begin
            if (opk) m_op = kc % 8;
            if (exe && m_op != 7) begin
               m_ph = P_WAIT;
               m_wcnt = 0;
               ack_at = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, TO + 3));
               forced_delay = -1;
            end
            if (back) m_ph = P_CLROP;
            if (clr) m_ph = P_CLRALL;
         end
         P_WAIT: begin
            if (clr) m_ph = P_CLRALL;
            else if (ack) begin m_res = ares; m_ov = aovf; m_ph = P_SHOW; end
            else if (m_wcnt == TO - 1) m_ph = P_ERR;
            else m_wcnt++;
         end
         P_SHOW: begin
            if (exe || clr) m_ph = P_CLRALL;
`ifdef CALC_CHAIN_EN
            else if (opk) begin m_a = m_res; m_b = 0; m_op = kc % 8; m_ov = 0; m_ph = P_ENTRY2; end
`endif
         end
         P_ERR: if (exe || clr) m_ph = P_CLRALL;
         default: begin m_a = 0; m_b = 0; m_op = 7; m_ov = 0; m_ph = P_ENTRY1; end
      endcase
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      e.op1 = W'(m_a);
      e.op2 = W'(m_b);
      e.op  = 3'(m_op);
      e.req = (m_ph == P_WAIT);
      e.err = (m_ph == P_ERR);
      e.ovf = (m_ph == P_SHOW) && m_ov;
      e.rej = m_rej;
      e.dv  = 1'b1;
      case (m_ph)
         P_ENTRY1:                 e.disp = W'(m_a);
         P_ENTRY2, P_SELOP, P_WAIT: e.disp = W'(m_b);
         P_SHOW:                   e.disp = W'(m_res);
         P_ERR:                    e.disp = '0;
         default: begin            e.disp = '0; e.dv = 1'b0; end
      endcase
      return e;
   endfunction

   // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
   task automatic cyc(input bit kv, input int unsigned kc, input bit r);
      bit ack, aovf;
      int unsigned ares;
      @(negedge clk);
      if (m_ph == P_WAIT) ack = (int'(m_wcnt) == ack_at);
      else                ack = ($urandom_range(0, 15) == 0);
      ares = fix_res ? fixed_res : ($urandom & ((1 << W) - 1));
      aovf = fix_res ? 1'b0 : 1'($urandom_range(0, 1));
      bus.key_valid  = kv;
      bus.key_code   = 5'(kc);
      bus.alu_ack    = ack;
      bus.alu_result = W'(ares);
      bus.alu_ovf    = aovf;
      rst            = r;
      model_step(kv, kc, ack, ares, aovf, r);
      exp_q.push_back(snapshot());
   endtask

   task automatic key(input int unsigned kc);
      cyc(1, kc, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0);
   endtask

   function automatic int unsigned rand_key();
      int unsigned p;
      p = $urandom_range(0, 99);
      if (p < 40) return $urandom_range(0, 15);
      if (p < 60) return 19;
      if (p < 75) begin
         p = $urandom_range(0, 4);
         return (p < 3) ? 16 + p : 17 + p;
      end
      if (p < 83) return 24;
      if (p < 89) return 22;
      if (p < 93) return 23;
      return $urandom_range(25, 31);
   endfunction

   // monitor: one expectation per clock edge, sampled 1 time unit later
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("op1", bus.op1, e.op1);
            chk("op2", bus.op2, e.op2);
            chk("op", bus.op, e.op);
            chk("alu_req", bus.alu_req, e.req);
            chk("err", bus.err, e.err);
            chk("ovf", bus.ovf, e.ovf);
            chk("digit_rej", bus.digit_rej, e.rej);
            if (e.dv) chk("display", bus.display, e.disp);
         end
      end
   end

   initial begin
      bus.key_valid = 0; bus.key_code = 0; bus.alu_ack = 0; bus.alu_result = '0; bus.alu_ovf = 0;
      cyc(0, 0, 1); cyc(0, 0, 1);
      // digit entry, overflow refusal, delete
      key(1); key(2); key(3); key(4); key(5); key(24); key(23); idle(2);
      // full operation with fixed ALU result, ack on third WAIT cycle
      fix_res = 1; fixed_res = 'h46;
      key(1); key(2); key(19); idle(1); key(3); key(4); key(19); idle(1);
      key(19); key(16); forced_delay = 2; key(19); idle(5);
      key(17); idle(2); key(23); idle(2);
      // BACK in OP2 and SEL_OP, EXE with no operator
      key(1); key(19); idle(1); key(5); key(22); idle(1); key(7); key(19); idle(1);
      key(18); key(22); idle(1); key(19); idle(1); key(23); idle(2);
      // timeout to ERR, leave with EXE
      key(1); key(19); idle(1); key(2); key(19); idle(1); key(20);
      forced_delay = 100; key(19); idle(10); key(19); idle(2);
      // CLEAR coinciding with ack
      key(19); idle(1); key(19); idle(1); key(21); forced_delay = 1; key(19); idle(1); key(23); idle(2);
      // reset during WAIT_ALU
      key(19); idle(1); key(19); idle(1); key(16); forced_delay = 100; key(19); idle(2);
      cyc(0, 0, 1); idle(2);
      fix_res = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0)       cyc(0, 0, 1);
         else if ($urandom_range(0, 1) == 0)    cyc(1, rand_key(), 0);
         else                                   cyc(0, 0, 0);
      end
      idle(1);
      repeat (3) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Parametrised keypad-to-ALU sequencer for the calculator datapath. It assembles two W-bit hex operands from debounced key pulses and captures an operator code. It then launches the operation on an external multi-cycle ALU over a req/ack handshake and presents the operand being edited, or the result, on a display bus. Compared with the previous single-width controller it adds:
- digit delete;
- an ALU timeout and error state;
- abort of an in-flight operation;
- optional result chaining.

## Interface
- W, 16: operand/result width in bits; multiple of 4, 8..32.
- TIMEOUT, 64: max cycles to wait for alu_ack before declaring error; ≥2.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  5  0_xxxx hex digit; 1_0000/1_0001/1_0010/1_0100/1_0101 operator (op = code[2:0]); 1_0011 EXE; 1_0110 BACK; 1_0111 CLEAR; 1_1000 DEL; others ignored.
- op1, op2  out  W  operand registers.
- op  out  3  operator; 3'b111 = none.
- alu_req  out  1  operation request (level).
- alu_ack  in  1  ALU done; alu_result/alu_ovf valid same cycle.
- alu_result  in  W  ALU result.
- alu_ovf  in  1  ALU overflow.
- display  out  W  value to show.
- ovf  out  1  overflow of the displayed result.
- err  out  1  high in ERR state.
- digit_rej  out  1  one-cycle pulse when a digit is refused (operand full).

## Operation
- States: OP1, CLR2, OP2, CLR_OP, SEL_OP, WAIT_ALU, SHOW, ERR, CLR_ALL. Only state transitions and register updates on a cycle with key_valid=1 consume a key; other keys in a state are ignored.
- OP1 (display=op1):
  - digit: if op1[W-1:W-4]==0, op1 ← {op1[W-5:0],digit}; else digit_rej pulse, op1 unchanged.
  - DEL: op1 ← op1>>4.
  - EXE → CLR2.
  - BACK or CLEAR → CLR_ALL.
- CLR2: op2←0 → OP2 (no key consumed).
- OP2 (display=op2): digit/DEL as OP1 on op2. EXE → CLR_OP; BACK → CLR2; CLEAR → CLR_ALL.
- CLR_OP: op←3'b111 → SEL_OP.
- SEL_OP (display=op2):
  - operator key: op←code[2:0].
  - EXE with op≠111 → WAIT_ALU; EXE with op==111 is ignored.
  - BACK → CLR_OP; CLEAR → CLR_ALL.
- WAIT_ALU (display=op2):
  - alu_req=1.
  - alu_ack=1: result←alu_result, ovf←alu_ovf → SHOW.
  - CLEAR: abort → CLR_ALL.
  - Other keys ignored.
  - Timeout counter reaches TIMEOUT with no ack → ERR.
- SHOW (display=result, ovf valid): EXE or CLEAR → CLR_ALL (see Configuration).
- ERR (display=0, err=1): EXE or CLEAR → CLR_ALL.
- CLR_ALL: op1←0, op2←0, op←111, ovf←0 → OP1.
- In SHOW, ovf shows the captured flag; outside SHOW, ovf=0.

## Timing
- Reset values (rst sampled high at a clock edge):
  - State, data and flags: state OP1, op1=op2=0, op=111, result=0, ovf=0, alu_req=0, err=0, digit_rej=0, timeout counter=0.
  - display=0, since display follows op1 in OP1.
- All registers update on posedge clk. display, err and alu_req decode the registered state and operand registers combinationally; no added latency.
- A key strobe updates state/operands at the next edge, visible one cycle after key_valid.
- Handshake:
  - alu_req rises the cycle after EXE is accepted in SEL_OP.
  - alu_req falls the cycle after alu_ack is sampled high.
  - op1, op2 and op are held constant while alu_req=1.
  - If alu_ack is already high on the first WAIT_ALU cycle, the result is captured that cycle.
- Timeout counter:
  - Clears on WAIT_ALU entry and increments each WAIT_ALU cycle.
  - ERR is entered when count==TIMEOUT-1 with no ack.
  - If ack and the timeout occur in the same cycle, ack wins.
- Simultaneous events in WAIT_ALU: CLEAR with alu_ack in the same cycle → CLEAR wins, result is discarded, and alu_req drops. Acks that arrive outside WAIT_ALU are ignored.
- rst mid-operation (including WAIT_ALU) drops alu_req at the next edge and returns to OP1.
- Back-to-back key strobes on consecutive cycles are each processed.

## Configuration
- CALC_CHAIN_EN defined: in SHOW, an operator key sets op1←result, op2←0, op←code[2:0], ovf←0 → OP2. The next EXE in OP2 → CLR_OP, so the operator must be re-confirmed. This allows chaining on the previous result.
- CALC_CHAIN_EN undefined: operator keys in SHOW are ignored; only EXE or CLEAR leaves SHOW.

## Test plan
- W=16: keys 1,2,3,4,5 → op1=0x1234; 5th digit gives digit_rej pulse; DEL → op1=0x0123.
- op1=0x0012, EXE, op2 keys 3,4, EXE, op 1_0000, EXE; ALU model acks after 3 cycles with 0x0046 → alu_req high exactly 3 cycles, display=0x0046, ovf=0.
- EXE in SEL_OP with op==111 → stays SEL_OP, alu_req=0. BACK in OP2 → op2=0. BACK in SEL_OP → op=111.
- TIMEOUT=8, ALU never acks → err=1 after 8 WAIT_ALU cycles, display=0; EXE → OP1, op1=0.
- CLEAR and alu_ack asserted in the same WAIT_ALU cycle → next cycle OP1, alu_req=0, result not shown; rst asserted in WAIT_ALU → all reset values.
- With CALC_CHAIN_EN, result 0x0046 shown, op key 1_0001 → op1=0x0046, op=001, state OP2, display=0.
